// File: rtl/snitch_icache_pkg.sv
// Package: snitch_icache_pkg
// Shared configuration record and fill-stage state encoding for the icache data path.
//   config_t      : geometry of the data SRAM and the refill beat width
//   DefaultCfg    : 256-bit lines, 64-bit refill beats, 2 sets, 7-bit line index
//   fill_state_e  : refill write stage states
//   fill_cfg_ok() : true when a line splits into a whole, non-zero number of beats
package snitch_icache_pkg;

    typedef struct packed {
        int unsigned LINE_WIDTH;
        int unsigned FILL_DW;
        int unsigned SET_COUNT;
        int unsigned COUNT_ALIGN;
    } config_t;

    localparam config_t DefaultCfg = '{
        LINE_WIDTH:  256,
        FILL_DW:     64,
        SET_COUNT:   2,
        COUNT_ALIGN: 7
    };

    typedef enum logic [1:0] {
        FillIdle,
        FillBeats,
        FillWrite,
        FillErr
    } fill_state_e;

    function automatic bit fill_cfg_ok(config_t cfg);
        return (cfg.FILL_DW != 0) && (cfg.LINE_WIDTH >= cfg.FILL_DW) &&
               ((cfg.LINE_WIDTH % cfg.FILL_DW) == 0);
    endfunction

endpackage

// File: rtl/snitch_icache_data_fill.sv
// Module: snitch_icache_data_fill
// Refill write stage in front of the icache data SRAM banks. Gathers refill beats into one full
// line and writes it to the selected set once the SRAM arbiter grants; errored lines are dropped
// and reported instead of written.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fill_req_*               line fill request (index, set); ready only while idle
//   beat_*                   refill beats (data, last flag, bus error); ready only while filling
//   ram_enable_o/write_o     one-hot set enable and write strobe towards the data SRAM
//   ram_addr_o/ram_wdata_o   line address and line data (replicated on every set)
//   ram_gnt_i                arbiter grant; the write takes place in the granted cycle
//   fill_done_o/fill_error_o completion pulse, qualified by error when the line was dropped
module snitch_icache_data_fill
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = DefaultCfg,
    localparam int unsigned SET_AW = (CFG.SET_COUNT > 1) ? $clog2(CFG.SET_COUNT) : 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          fill_req_valid_i,
    output logic                                          fill_req_ready_o,
    input  logic [CFG.COUNT_ALIGN-1:0]                    fill_req_index_i,
    input  logic [SET_AW-1:0]                             fill_req_set_i,
    input  logic                                          beat_valid_i,
    output logic                                          beat_ready_o,
    input  logic [CFG.FILL_DW-1:0]                        beat_data_i,
    input  logic                                          beat_last_i,
    input  logic                                          beat_error_i,
    output logic [CFG.SET_COUNT-1:0]                      ram_enable_o,
    output logic                                          ram_write_o,
    output logic [CFG.COUNT_ALIGN-1:0]                    ram_addr_o,
    output logic [CFG.SET_COUNT-1:0][CFG.LINE_WIDTH-1:0]  ram_wdata_o,
    input  logic                                          ram_gnt_i,
    output logic                                          fill_done_o,
    output logic                                          fill_error_o
);

    localparam int unsigned LW    = CFG.LINE_WIDTH;
    localparam int unsigned DW    = CFG.FILL_DW;
    localparam int unsigned SETS  = CFG.SET_COUNT;
    localparam int unsigned AW    = CFG.COUNT_ALIGN;
    localparam int unsigned BEATS = LW / DW;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BEATS - 1);

    if (!fill_cfg_ok(CFG)) begin : gen_cfg_check
        $error("LINE_WIDTH must be a non-zero whole multiple of FILL_DW");
    end

    fill_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LW-1:0]     line_q;
    logic [AW-1:0]     index_q;
    logic [SET_AW-1:0] set_q;
    logic              err_q;

    logic beat_last_ok;
    logic err_next;
    logic in_write;

    // The counter decides where the line ends; beat_last_i is only cross-checked against it.
    assign beat_last_ok = (beat_last_i == (cnt_q == LastCnt));
    assign err_next     = err_q | beat_error_i | ~beat_last_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FillIdle;
            cnt_q   <= '0;
            line_q  <= '0;
            index_q <= '0;
            set_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                FillIdle: begin
                    if (fill_req_valid_i) begin
                        index_q <= fill_req_index_i;
                        set_q   <= fill_req_set_i;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= FillBeats;
                    end
                end
                FillBeats: begin
                    if (beat_valid_i) begin
                        line_q[32'(cnt_q) * DW +: DW] <= beat_data_i;
                        cnt_q <= cnt_q + 1'b1;
                        err_q <= err_next;
                        if (cnt_q == LastCnt) begin
                            state_q <= err_next ? FillErr : FillWrite;
                        end
                    end
                end
                FillWrite: begin
                    if (ram_gnt_i) begin
                        state_q <= FillIdle;
                    end
                end
                FillErr: begin
                    state_q <= FillIdle;
                end
                default: begin
                    state_q <= FillIdle;
                end
            endcase
        end
    end

    // SRAM-facing outputs depend on state and registers only; the grant never feeds them.
    always_comb begin
        in_write         = (state_q == FillWrite);
        fill_req_ready_o = (state_q == FillIdle);
        beat_ready_o     = (state_q == FillBeats);
        ram_write_o      = in_write;
        ram_enable_o     = in_write ? (SETS'(1) << set_q) : '0;
        ram_addr_o       = in_write ? index_q : '0;
        ram_wdata_o      = in_write ? {SETS{line_q}} : '0;
        fill_done_o      = (in_write && ram_gnt_i) || (state_q == FillErr);
        fill_error_o     = (state_q == FillErr);
    end

endmodule

// File: tb/tb_snitch_icache_data_fill.sv
module tb_snitch_icache_data_fill;
    import snitch_icache_pkg::*;

    localparam config_t Cfg = '{LINE_WIDTH: 256, FILL_DW: 64, SET_COUNT: 2, COUNT_ALIGN: 7};
    localparam int LW = 256;
    localparam int DW = 64;
    localparam int SC = 2;
    localparam int NB = 4;
    localparam logic [LW-1:0] CleanLine = {64'h3, 64'h2, 64'h1, 64'h0};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               fill_req_valid = 1'b0;
    logic               fill_req_ready;
    logic [6:0]         fill_req_index = '0;
    logic [0:0]         fill_req_set = '0;
    logic               beat_valid = 1'b0;
    logic               beat_ready;
    logic [DW-1:0]      beat_data = '0;
    logic               beat_last = 1'b0;
    logic               beat_error = 1'b0;
    logic [SC-1:0]      ram_enable;
    logic               ram_write;
    logic [6:0]         ram_addr;
    logic [SC-1:0][LW-1:0] ram_wdata;
    logic               ram_gnt = 1'b0;
    logic               fill_done;
    logic               fill_error;

    int gnt_mode = 0;  // 0: always granted, 1: random grant, 2: grant withheld

    snitch_icache_data_fill #(.CFG(Cfg)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .fill_req_valid_i (fill_req_valid),
        .fill_req_ready_o (fill_req_ready),
        .fill_req_index_i (fill_req_index),
        .fill_req_set_i   (fill_req_set),
        .beat_valid_i     (beat_valid),
        .beat_ready_o     (beat_ready),
        .beat_data_i      (beat_data),
        .beat_last_i      (beat_last),
        .beat_error_i     (beat_error),
        .ram_enable_o     (ram_enable),
        .ram_write_o      (ram_write),
        .ram_addr_o       (ram_addr),
        .ram_wdata_o      (ram_wdata),
        .ram_gnt_i        (ram_gnt),
        .fill_done_o      (fill_done),
        .fill_error_o     (fill_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (gnt_mode)
            0: ram_gnt = 1'b1;
            1: ram_gnt = ($urandom_range(0, 2) == 0);
            default: ram_gnt = 1'b0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a fill is "collecting" until NB beats arrived, then either a pending
    // line write (held until granted) or a one-cycle error report.
    bit            m_idle = 1'b1;
    bit            m_collect = 1'b0;
    bit            m_wr = 1'b0;
    bit            m_errdone = 1'b0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_beats[$];
    logic [LW-1:0] m_line = '0;
    logic [6:0]    m_idx = '0;
    logic          m_set = 1'b0;

    int cyc = 0;
    int n_done = 0;
    int n_err_done = 0;
    int n_wr_cyc = 0;
    int n_writes = 0;
    int n_beats = 0;
    int last_done_cyc = 0;

    always @(negedge clk) begin
        logic [SC-1:0]  e_en;
        logic [511:0]   e_wd;
        logic           e_done;
        cyc++;
        if (!rst_n) begin
            m_idle = 1'b1; m_collect = 1'b0; m_wr = 1'b0; m_errdone = 1'b0; m_err = 1'b0;
            m_beats.delete(); m_line = '0; m_idx = '0; m_set = 1'b0;
        end
        assert (!(fill_req_valid && int'(fill_req_set) >= SC))
            else $error("request set out of range");
        e_en   = m_wr ? (SC'(1) << m_set) : '0;
        e_wd   = m_wr ? {m_line, m_line} : '0;
        e_done = (m_wr && ram_gnt) || m_errdone;
        check("fill_req_ready", fill_req_ready, m_idle);
        check("beat_ready", beat_ready, m_collect);
        check("ram_enable", ram_enable, e_en);
        check("ram_write", ram_write, m_wr);
        check("ram_addr", ram_addr, m_wr ? m_idx : 7'h0);
        check("ram_wdata", ram_wdata, e_wd);
        check("fill_done", fill_done, e_done);
        check("fill_error", fill_error, m_errdone);

        if (fill_done) begin
            n_done++;
            last_done_cyc = cyc;
            if (fill_error) n_err_done++;
        end
        if (ram_write) n_wr_cyc++;
        if (ram_write && ram_gnt) n_writes++;
        if (beat_valid && beat_ready) n_beats++;

        if (rst_n) begin
            if (m_idle) begin
                if (fill_req_valid) begin
                    m_idle = 1'b0; m_collect = 1'b1; m_err = 1'b0; m_beats.delete();
                    m_idx = fill_req_index; m_set = fill_req_set[0];
                end
            end else if (m_collect) begin
                if (beat_valid) begin
                    if (beat_error || (beat_last != (m_beats.size() == NB - 1))) m_err = 1'b1;
                    m_beats.push_back(beat_data);
                    if (m_beats.size() == NB) begin
                        m_collect = 1'b0;
                        if (m_err) m_errdone = 1'b1;
                        else begin
                            m_wr = 1'b1;
                            for (int k = 0; k < NB; k++) m_line[k*DW +: DW] = m_beats[k];
                        end
                    end
                end
            end else if (m_wr) begin
                if (ram_gnt) begin
                    m_wr = 1'b0; m_idle = 1'b1;
                end
            end else if (m_errdone) begin
                m_errdone = 1'b0; m_idle = 1'b1;
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [6:0] idx, input logic set);
        bit acc;
        acc = 1'b0;
        fill_req_valid = 1'b1;
        fill_req_index = idx;
        fill_req_set   = set;
        for (int t = 0; t < 300 && !acc; t++) begin
            sample();
            acc = fill_req_ready;
            next_cycle();
        end
        fill_req_valid = 1'b0;
        if (!acc) check("req_handshake_timeout", acc, 1);
    endtask

    task automatic send_beats(input logic [NB-1:0][DW-1:0] d, input logic [NB-1:0] lastm,
                              input logic [NB-1:0] errm, input int duty, input int nb);
        bit acc;
        for (int k = 0; k < nb; k++) begin
            acc = 1'b0;
            for (int g = 0; g < 50 && duty < 100 && $urandom_range(0, 99) >= duty; g++) begin
                beat_valid = 1'b0;
                next_cycle();
            end
            beat_valid = 1'b1;
            beat_data  = d[k];
            beat_last  = lastm[k];
            beat_error = errm[k];
            for (int t = 0; t < 300 && !acc; t++) begin
                sample();
                acc = beat_ready;
                next_cycle();
            end
            if (!acc) begin
                check("beat_handshake_timeout", acc, 1);
                break;
            end
        end
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_error = 1'b0;
    endtask

    // Leaves the caller at the sample point of the done cycle.
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            sample();
            seen = fill_done;
        end
        if (!seen) check("done_timeout", seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0][DW-1:0] clean_d;
        logic [NB-1:0][DW-1:0] rd;
        logic [NB-1:0]         lastm;
        logic [NB-1:0]         errm;
        int  t0, d_done, d_err, d_wrc, d_wr, d_beats, wc, n_clean;
        bit  seen;

        clean_d = {64'h3, 64'h2, 64'h1, 64'h0};

        // Reset values
        repeat (3) @(posedge clk);
        sample();
        check("reset_ready", fill_req_ready, 1);
        check("reset_beat_ready", beat_ready, 0);
        check("reset_enable", ram_enable, 0);
        check("reset_write", ram_write, 0);
        check("reset_done", fill_done, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Clean fill, immediate grant
        gnt_mode = 0;
        d_wr = n_writes;
        t0 = cyc;
        send_req(7'h15, 1'b1);
        send_beats(clean_d, 4'b1000, 4'b0000, 100, NB);
        sample();
        check("clean_done", fill_done, 1);
        check("clean_error", fill_error, 0);
        check("clean_enable", ram_enable, 2'b10);
        check("clean_addr", ram_addr, 7'h15);
        check("clean_line_set0", ram_wdata[0], CleanLine);
        check("clean_line_set1", ram_wdata[1], CleanLine);
        check("clean_done_cycle", last_done_cyc - t0, 6);
        next_cycle();
        sample();
        check("clean_back_idle", fill_req_ready, 1);
        check("clean_single_write", n_writes - d_wr, 1);
        next_cycle();

        // Grant withheld for 5 write cycles
        gnt_mode = 2;
        d_done = n_done; d_wrc = n_wr_cyc; d_wr = n_writes;
        send_req(7'h15, 1'b1);
        send_beats(clean_d, 4'b1000, 4'b0000, 100, NB);
        wc = 0;
        for (int t = 0; t < 100 && wc < 5; t++) begin
            sample();
            if (ram_write) wc++;
        end
        check("stall_write_cycles_seen", wc, 5);
        gnt_mode = 0;
        wait_done(seen);
        check("stall_wdata_at_grant", ram_wdata[1], CleanLine);
        next_cycle();
        check("stall_write_cycles", n_wr_cyc - d_wrc, 6);
        check("stall_single_write", n_writes - d_wr, 1);
        check("stall_single_done", n_done - d_done, 1);

        // Bus error on beat 2
        d_err = n_err_done; d_wrc = n_wr_cyc;
        send_req(7'h33, 1'b0);
        send_beats(clean_d, 4'b1000, 4'b0100, 100, NB);
        wait_done(seen);
        check("buserr_error_flag", fill_error, 1);
        next_cycle();
        check("buserr_no_write", n_wr_cyc - d_wrc, 0);
        check("buserr_err_done", n_err_done - d_err, 1);

        // beat_last on beat 1: still four beats, dropped
        d_err = n_err_done; d_wrc = n_wr_cyc; d_beats = n_beats;
        send_req(7'h40, 1'b1);
        send_beats(clean_d, 4'b0010, 4'b0000, 100, NB);
        wait_done(seen);
        check("lastmis_error_flag", fill_error, 1);
        next_cycle();
        check("lastmis_beats", n_beats - d_beats, 4);
        check("lastmis_no_write", n_wr_cyc - d_wrc, 0);
        check("lastmis_err_done", n_err_done - d_err, 1);

        // Sparse beats
        send_req(7'h07, 1'b0);
        send_beats(clean_d, 4'b1000, 4'b0000, 30, NB);
        wait_done(seen);
        check("gaps_error", fill_error, 0);
        check("gaps_enable", ram_enable, 2'b01);
        check("gaps_line", ram_wdata[0], CleanLine);
        next_cycle();

        // Reset after two beats
        d_done = n_done; d_wrc = n_wr_cyc;
        send_req(7'h11, 1'b1);
        send_beats(clean_d, 4'b1000, 4'b0000, 100, 2);
        rst_n = 1'b0;
        sample();
        check("midrst_ready", fill_req_ready, 1);
        check("midrst_beat_ready", beat_ready, 0);
        next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
        check("midrst_no_done", n_done - d_done, 0);
        check("midrst_no_write", n_wr_cyc - d_wrc, 0);
        send_req(7'h2a, 1'b0);
        send_beats(clean_d, 4'b1000, 4'b0000, 100, NB);
        sample();
        check("postrst_done", fill_done, 1);
        check("postrst_addr", ram_addr, 7'h2a);
        check("postrst_line", ram_wdata[0], CleanLine);
        next_cycle();

        // Randomized fills; the next request and beats are raised while the last line drains
        gnt_mode = 1;
        d_done = n_done; d_err = n_err_done; d_wr = n_writes;
        n_clean = 0;
        for (int i = 0; i < 40; i++) begin
            int r;
            for (int k = 0; k < NB; k++) rd[k] = {$urandom, $urandom};
            lastm = 4'b1000;
            errm  = 4'b0000;
            r = $urandom_range(0, 9);
            if (r < 2) errm = 4'b0001 << $urandom_range(0, 3);
            else if (r == 2) begin
                lastm = 4'($urandom_range(0, 15));
                if (lastm == 4'b1000) lastm = 4'b0001;
            end else n_clean++;
            fork
                send_req(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
                send_beats(rd, lastm, errm, ($urandom_range(0, 1) == 0) ? 30 : 100, NB);
            join
            repeat ($urandom_range(0, 2)) next_cycle();
        end
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            sample();
            seen = fill_req_ready;
        end
        next_cycle();
        check("rand_drained", seen, 1);
        check("rand_done_count", n_done - d_done, 40);
        check("rand_write_count", n_writes - d_wr, n_clean);
        check("rand_err_count", n_err_done - d_err, 40 - n_clean);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
